fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage of the 16-bit RISC pipeline. It owns the PC and drives the instruction-memory address. It assembles one- and two-word instructions into an instruction/immediate pair and registers them into the IF/ID boundary consumed by the decode stage. It also handles boot-vector load, branch redirects, pipeline stalls and interrupt-vector entry.

## Interface
Parameters:
- BOOT_ADDR, 16'h0000, imem word holding the reset PC
- INT_ADDR, 16'h0001, imem word holding the interrupt handler address

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- imem_addr  out  16  instruction memory word address (combinational from state/PC)
- imem_data  in  16  instruction memory read data, valid same cycle as imem_addr (asynchronous read)
- stall  in  1  hazard unit hold; freezes PC, state and outputs
- branch_taken  in  1  redirect request from a later stage
- branch_target  in  16  redirect address
- interrupt  in  1  level interrupt request
- instruction  out  16  registered instruction to decode
- immediate  out  16  registered second word; 0 for one-word instructions
- pc_next  out  16  registered address following the emitted instruction (return address)
- fetch_valid  out  1  registered; instruction/immediate form a real instruction
- int_taken  out  1  registered one-cycle pulse on interrupt vector entry
- int_return_pc  out  16  registered PC saved at interrupt entry

## Operation
- State register: BOOT, FETCH, IMM, INTV. Reset value: BOOT.
- Two-word encoding: instruction[15:14] == 2'b10 means the next imem word is its immediate.
- int_pending is set whenever interrupt=1. It is cleared on entry to INTV.
- Priority per cycle: branch_taken > stall > normal progress.
- BOOT:
  - imem_addr=BOOT_ADDR; PC<=imem_data; ->FETCH.
  - fetch_valid<=0. Stall and branch_taken are ignored.
- FETCH, imem_addr=PC:
  - branch_taken: PC<=branch_target, fetch_valid<=0, stay FETCH.
  - stall: hold everything.
  - int_pending: int_return_pc<=PC, fetch_valid<=0, ->INTV.
  - One-word instruction:
    - instruction<=imem_data, immediate<=0, pc_next<=PC+1, fetch_valid<=1.
    - PC<=PC+1.
  - Two-word instruction:
    - held<=imem_data, PC<=PC+1, fetch_valid<=0, ->IMM.
- IMM, imem_addr=PC:
  - branch_taken: discard held, PC<=branch_target, fetch_valid<=0, ->FETCH.
  - stall: hold.
  - Otherwise:
    - instruction<=held, immediate<=imem_data, pc_next<=PC+1, fetch_valid<=1.
    - PC<=PC+1, ->FETCH.
  - Interrupts are never taken between the two words.
- INTV, imem_addr=INT_ADDR:
  - PC<=imem_data, int_taken<=1 for this one cycle, int_pending<=0, fetch_valid<=0, ->FETCH.
  - branch_taken in INTV is ignored.
- PC arithmetic is 16-bit modulo: 16'hFFFF+1 = 16'h0000. An IMM word fetched across the wrap comes from address 0.
- Reset values: instruction, immediate, pc_next, int_return_pc = 16'h0000; fetch_valid, int_taken = 0; PC=0; held=0; int_pending=0.
- Reset asserted mid-IMM or mid-INTV abandons the operation and returns to BOOT.

## Timing
- Address-to-output latency:
  - One-word instruction: 1 cycle.
  - Two-word instruction: 2 cycles, with fetch_valid=0 in the first.
- First valid instruction appears at earliest 2 cycles after reset deassertion (BOOT, then FETCH).
- Branch redirect: target word is on imem_addr the cycle after branch_taken is sampled. fetch_valid is 0 in the redirect cycle.
- Interrupt latency: at most 2 cycles from interrupt at an instruction boundary (FETCH→INTV), plus stall cycles. A pending interrupt waits out IMM.
- Stall is fully transparent: outputs are bit-identical across all stalled cycles.
- int_taken is high for exactly 1 cycle per entry.

## Test plan
- Boot:
  - Stimulus: imem[0]=16'h0020, imem[0x20]=16'h1800 (one-word).
  - Required: cycle 2 outputs instruction=16'h1800, immediate=0, pc_next=16'h0021, fetch_valid=1.
- Two-word:
  - Stimulus: imem[0x20]=16'h8A00, imem[0x21]=16'h1234.
  - Required: fetch_valid=0, then instruction=16'h8A00, immediate=16'h1234, pc_next=16'h0022, fetch_valid=1.
- Branch in IMM:
  - Stimulus: assert branch_taken with target 16'h0050 during IMM.
  - Required: next imem_addr=16'h0050; no output with instruction=16'h8A00.
- Stall:
  - Stimulus: hold stall 3 cycles mid-stream.
  - Required: PC, imem_addr and all outputs constant; stream resumes with no lost or duplicated instruction.
- Interrupt:
  - Stimulus: imem[1]=16'h0100; pulse interrupt during IMM of 16'h8A00 at 0x20.
  - Required: two-word pair emitted first, then int_taken=1 with int_return_pc=16'h0022; next imem_addr=16'h0100.
- Wrap and reset:
  - Stimulus: PC=16'hFFFF with a one-word instruction; then assert reset mid-IMM.
  - Required: pc_next=16'h0000; reset returns all outputs to 0 immediately and state to BOOT.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, boot/interrupt vectors, two-word assembly, IF/ID register
module fetch_stage #(
  parameter logic [15:0] BOOT_ADDR = 16'h0000,
  parameter logic [15:0] INT_ADDR  = 16'h0001
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        interrupt,
  output logic [15:0] instruction,
  output logic [15:0] immediate,
  output logic [15:0] pc_next,
  output logic        fetch_valid,
  output logic        int_taken,
  output logic [15:0] int_return_pc
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_IMM   = 2'd2;
  localparam logic [1:0] S_INTV  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] held_q, held_d;
  logic        int_pending_q, int_pending_d;
  logic [15:0] instruction_q, instruction_d;
  logic [15:0] immediate_q, immediate_d;
  logic [15:0] pc_next_q, pc_next_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        int_taken_q, int_taken_d;
  logic [15:0] int_return_pc_q, int_return_pc_d;
  logic [15:0] pc_inc;

  assign pc_inc = pc_q + 16'd1;

  always_comb begin
    case (state_q)
      S_BOOT:  imem_addr = BOOT_ADDR;
      S_INTV:  imem_addr = INT_ADDR;
      default: imem_addr = pc_q;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    held_d          = held_q;
    int_pending_d   = int_pending_q | interrupt;
    instruction_d   = instruction_q;
    immediate_d     = immediate_q;
    pc_next_d       = pc_next_q;
    fetch_valid_d   = fetch_valid_q;
    int_taken_d     = 1'b0;
    int_return_pc_d = int_return_pc_q;
    case (state_q)
      S_BOOT: begin
        pc_d          = imem_data;
        fetch_valid_d = 1'b0;
        state_d       = S_FETCH;
      end
      S_FETCH: begin
        if (branch_taken) begin
          pc_d          = branch_target;
          fetch_valid_d = 1'b0;
        end else if (stall) begin
          int_taken_d = int_taken_q;
        end else if (int_pending_q) begin
          int_return_pc_d = pc_q;
          int_pending_d   = 1'b0;
          fetch_valid_d   = 1'b0;
          state_d         = S_INTV;
        end else if (imem_data[15:14] == 2'b10) begin
          held_d        = imem_data;
          pc_d          = pc_inc;
          fetch_valid_d = 1'b0;
          state_d       = S_IMM;
        end else begin
          instruction_d = imem_data;
          immediate_d   = 16'h0000;
          pc_next_d     = pc_inc;
          fetch_valid_d = 1'b1;
          pc_d          = pc_inc;
        end
      end
      S_IMM: begin
        // Pending interrupts wait here; they are only taken back in FETCH.
        if (branch_taken) begin
          held_d        = 16'h0000;
          pc_d          = branch_target;
          fetch_valid_d = 1'b0;
          state_d       = S_FETCH;
        end else if (stall) begin
          int_taken_d = int_taken_q;
        end else begin
          instruction_d = held_q;
          immediate_d   = imem_data;
          pc_next_d     = pc_inc;
          fetch_valid_d = 1'b1;
          pc_d          = pc_inc;
          state_d       = S_FETCH;
        end
      end
      default: begin
        if (stall) begin
          int_taken_d = int_taken_q;
        end else begin
          pc_d          = imem_data;
          int_taken_d   = 1'b1;
          int_pending_d = 1'b0;
          fetch_valid_d = 1'b0;
          state_d       = S_FETCH;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_BOOT;
      pc_q            <= 16'h0000;
      held_q          <= 16'h0000;
      int_pending_q   <= 1'b0;
      instruction_q   <= 16'h0000;
      immediate_q     <= 16'h0000;
      pc_next_q       <= 16'h0000;
      fetch_valid_q   <= 1'b0;
      int_taken_q     <= 1'b0;
      int_return_pc_q <= 16'h0000;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      held_q          <= held_d;
      int_pending_q   <= int_pending_d;
      instruction_q   <= instruction_d;
      immediate_q     <= immediate_d;
      pc_next_q       <= pc_next_d;
      fetch_valid_q   <= fetch_valid_d;
      int_taken_q     <= int_taken_d;
      int_return_pc_q <= int_return_pc_d;
    end
  end

  assign instruction   = instruction_q;
  assign immediate     = immediate_q;
  assign pc_next       = pc_next_q;
  assign fetch_valid   = fetch_valid_q;
  assign int_taken     = int_taken_q;
  assign int_return_pc = int_return_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        interrupt;
  logic [15:0] instruction;
  logic [15:0] immediate;
  logic [15:0] pc_next;
  logic        fetch_valid;
  logic        int_taken;
  logic [15:0] int_return_pc;

  logic [15:0] mem [0:65535];
  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] imm;
    logic [15:0] pcn;
  } exp_t;
  exp_t exp_q[$];

  logic [81:0] obs;
  assign obs = {instruction, immediate, pc_next, fetch_valid, int_taken, int_return_pc, imem_addr};
  assign imem_data = mem[imem_addr];

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .interrupt(interrupt), .instruction(instruction), .immediate(immediate),
    .pc_next(pc_next), .fetch_valid(fetch_valid), .int_taken(int_taken),
    .int_return_pc(int_return_pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
  endtask

  task automatic start(input logic [15:0] boot_pc);
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000; interrupt = 1'b0;
    mem[0] = boot_pc;
    tick();
    reset = 1'b0;
  endtask

  // Expected instruction stream from a start address, derived from memory contents alone.
  task automatic build_stream(input logic [15:0] from_pc, input int n);
    logic [15:0] pc;
    exp_t e;
    pc = from_pc;
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      e.instr = mem[pc];
      if (e.instr[15:14] == 2'b10) begin
        e.imm = mem[pc + 16'd1];
        pc = pc + 16'd2;
      end else begin
        e.imm = 16'h0000;
        pc = pc + 16'd1;
      end
      e.pcn = pc;
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000; interrupt = 1'b0;
    tick();
    checks++;
    if (obs !== 82'd0) begin
      failures++;
      $display("FAIL reset_state got=%h expected=0", obs);
    end
  endtask

  task automatic test_boot();
    clear_mem();
    mem[16'h0020] = 16'h1800;
    start(16'h0020);
    tick();
    checks++;
    if ({imem_addr, fetch_valid} !== {16'h0020, 1'b0}) begin
      failures++;
      $display("FAIL boot_cycle1 got addr=%h valid=%b expected addr=0020 valid=0", imem_addr, fetch_valid);
    end
    tick();
    checks++;
    if ({instruction, immediate, pc_next, fetch_valid} !== {16'h1800, 16'h0000, 16'h0021, 1'b1}) begin
      failures++;
      $display("FAIL boot_first_instr got %h %h %h %b expected 1800 0000 0021 1",
               instruction, immediate, pc_next, fetch_valid);
    end
  endtask

  task automatic test_two_word();
    clear_mem();
    mem[16'h0020] = 16'h8A00;
    mem[16'h0021] = 16'h1234;
    start(16'h0020);
    tick(); tick();
    checks++;
    if ({imem_addr, fetch_valid} !== {16'h0021, 1'b0}) begin
      failures++;
      $display("FAIL two_word_first got addr=%h valid=%b expected addr=0021 valid=0", imem_addr, fetch_valid);
    end
    tick();
    checks++;
    if ({instruction, immediate, pc_next, fetch_valid} !== {16'h8A00, 16'h1234, 16'h0022, 1'b1}) begin
      failures++;
      $display("FAIL two_word_pair got %h %h %h %b expected 8a00 1234 0022 1",
               instruction, immediate, pc_next, fetch_valid);
    end
  endtask

  task automatic test_branch_imm();
    clear_mem();
    mem[16'h0020] = 16'h8A00;
    mem[16'h0021] = 16'h1234;
    mem[16'h0050] = 16'h1111;
    start(16'h0020);
    tick(); tick();
    branch_taken = 1'b1;
    branch_target = 16'h0050;
    tick();
    branch_taken = 1'b0;
    checks++;
    if ({imem_addr, fetch_valid} !== {16'h0050, 1'b0}) begin
      failures++;
      $display("FAIL branch_redirect got addr=%h valid=%b expected addr=0050 valid=0", imem_addr, fetch_valid);
    end
    tick();
    checks++;
    if ({instruction, immediate, pc_next, fetch_valid} !== {16'h1111, 16'h0000, 16'h0051, 1'b1}) begin
      failures++;
      $display("FAIL branch_target_instr got %h %h %h %b expected 1111 0000 0051 1",
               instruction, immediate, pc_next, fetch_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (instruction === 16'h8A00) begin
        failures++;
        $display("FAIL branch_discard got instruction=%h expected not 8a00", instruction);
      end
    end
  endtask

  task automatic test_interrupt();
    clear_mem();
    mem[16'h0001] = 16'h0100;
    mem[16'h0020] = 16'h8A00;
    mem[16'h0021] = 16'h1234;
    mem[16'h0100] = 16'h1800;
    start(16'h0020);
    tick(); tick();
    interrupt = 1'b1;
    tick();
    interrupt = 1'b0;
    checks++;
    if ({instruction, immediate, pc_next, fetch_valid, int_taken} !== {16'h8A00, 16'h1234, 16'h0022, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL int_pair_first got %h %h %h %b %b expected 8a00 1234 0022 1 0",
               instruction, immediate, pc_next, fetch_valid, int_taken);
    end
    tick();
    checks++;
    if ({imem_addr, fetch_valid, int_return_pc, int_taken} !== {16'h0001, 1'b0, 16'h0022, 1'b0}) begin
      failures++;
      $display("FAIL int_vector_fetch got addr=%h valid=%b ret=%h taken=%b expected 0001 0 0022 0",
               imem_addr, fetch_valid, int_return_pc, int_taken);
    end
    tick();
    checks++;
    if ({int_taken, int_return_pc, imem_addr} !== {1'b1, 16'h0022, 16'h0100}) begin
      failures++;
      $display("FAIL int_entry got taken=%b ret=%h addr=%h expected 1 0022 0100", int_taken, int_return_pc, imem_addr);
    end
    tick();
    checks++;
    if ({int_taken, instruction, pc_next, fetch_valid} !== {1'b0, 16'h1800, 16'h0101, 1'b1}) begin
      failures++;
      $display("FAIL int_handler got taken=%b %h %h %b expected 0 1800 0101 1",
               int_taken, instruction, pc_next, fetch_valid);
    end
  endtask

  task automatic test_wrap_reset();
    clear_mem();
    mem[16'hFFFF] = 16'h1800;
    mem[16'h0001] = 16'h8A00;
    start(16'hFFFF);
    tick(); tick();
    checks++;
    if ({instruction, pc_next, fetch_valid} !== {16'h1800, 16'h0000, 1'b1}) begin
      failures++;
      $display("FAIL wrap_one_word got %h %h %b expected 1800 0000 1", instruction, pc_next, fetch_valid);
    end
    tick();
    checks++;
    if ({instruction, immediate, pc_next, fetch_valid} !== {16'hFFFF, 16'h0000, 16'h0001, 1'b1}) begin
      failures++;
      $display("FAIL wrap_after got %h %h %h %b expected ffff 0000 0001 1",
               instruction, immediate, pc_next, fetch_valid);
    end
    tick();
    checks++;
    if ({imem_addr, fetch_valid} !== {16'h0002, 1'b0}) begin
      failures++;
      $display("FAIL wrap_enter_imm got addr=%h valid=%b expected 0002 0", imem_addr, fetch_valid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== 82'd0) begin
      failures++;
      $display("FAIL reset_mid_imm got=%h expected=0", obs);
    end
    tick();
    reset = 1'b0;
    tick(); tick();
    checks++;
    if ({instruction, pc_next, fetch_valid} !== {16'h1800, 16'h0000, 1'b1}) begin
      failures++;
      $display("FAIL reboot got %h %h %b expected 1800 0000 1", instruction, pc_next, fetch_valid);
    end
    clear_mem();
    mem[16'hFFFF] = 16'h8AAA;
    start(16'hFFFF);
    tick(); tick();
    checks++;
    if (imem_addr !== 16'h0000) begin
      failures++;
      $display("FAIL wrap_imm_addr got %h expected 0000", imem_addr);
    end
    tick();
    checks++;
    if ({instruction, immediate, pc_next, fetch_valid} !== {16'h8AAA, 16'hFFFF, 16'h0001, 1'b1}) begin
      failures++;
      $display("FAIL wrap_imm_pair got %h %h %h %b expected 8aaa ffff 0001 1",
               instruction, immediate, pc_next, fetch_valid);
    end
  endtask

  task automatic test_stream();
    logic [81:0] snap;
    logic [15:0] w;
    logic        br;
    logic        st;
    logic [15:0] tgt;
    exp_t        e;
    int          emitted;
    emitted = 0;
    clear_mem();
    for (int a = 2; a < 16'h0400; a++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 2) == 0) w[15:14] = 2'b10;
      else if (w[15:14] == 2'b10) w[15:14] = 2'b00;
      mem[a] = w;
    end
    start(16'h0020);
    build_stream(16'h0020, 300);
    tick();
    for (int cyc = 0; cyc < 250; cyc++) begin
      br  = ($urandom_range(0, 19) == 0) && !(cyc >= 40 && cyc <= 42);
      tgt = 16'($urandom_range(16'h0020, 16'h02FF));
      st  = (cyc >= 40 && cyc <= 42) ? 1'b1 : ($urandom_range(0, 5) == 0);
      branch_taken  = br;
      branch_target = tgt;
      stall         = st;
      snap = obs;
      tick();
      if (br) begin
        build_stream(tgt, 300);
        checks++;
        if ({imem_addr, fetch_valid} !== {tgt, 1'b0}) begin
          failures++;
          $display("FAIL stream_branch got addr=%h valid=%b expected addr=%h valid=0", imem_addr, fetch_valid, tgt);
        end
      end else if (st) begin
        checks++;
        if (obs !== snap) begin
          failures++;
          $display("FAIL stream_stall_hold got=%h expected=%h", obs, snap);
        end
      end else if (fetch_valid) begin
        emitted++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL stream_emit got %h %h %h expected no further instruction", instruction, immediate, pc_next);
        end else begin
          e = exp_q.pop_front();
          if ({instruction, immediate, pc_next} !== {e.instr, e.imm, e.pcn}) begin
            failures++;
            $display("FAIL stream_emit got %h %h %h expected %h %h %h",
                     instruction, immediate, pc_next, e.instr, e.imm, e.pcn);
          end
        end
      end
    end
    branch_taken = 1'b0;
    stall = 1'b0;
    checks++;
    if (emitted < 50) begin
      failures++;
      $display("FAIL stream_progress got %0d instructions expected at least 50", emitted);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000; interrupt = 1'b0;
    test_reset();
    test_boot();
    test_two_word();
    test_branch_imm();
    test_interrupt();
    test_wrap_reset();
    test_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
